// File: rtl/seq_demux_pkg.sv
// Shared definitions for the sequential demultiplexer: FSM state encoding,
// mode encoding and a small helper that maps the mode input onto a state.
package seq_demux_pkg;

  // FSM state type; kept as plain sized constants for legacy tools.
  typedef logic [0:0] state_t;

  localparam state_t ST_ADDR = 1'b0;
  localparam state_t ST_AUTO = 1'b1;

  // Encoding of the mode input.
  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_AUTO = 1'b1;

  // The FSM simply follows the mode input every cycle.
  function automatic state_t mode_to_state(input logic mode_i);
    state_t st;
    if (mode_i == MODE_AUTO) begin
      st = ST_AUTO;
    end else begin
      st = ST_ADDR;
    end
    return st;
  endfunction

endpackage

// File: rtl/seq_demux_chan_hold.sv
// One channel hold register: loads a word when enabled, otherwise keeps its
// value forever. Reset clears it.
module chan_hold_reg
  import seq_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Hold register with load enable; reset has priority over a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= {WIDTH{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/seq_demux_chk.sv
// Protocol checker for seq_demux outputs. Purely observational.
module seq_demux_chk
  import seq_demux_pkg::*;
#(
  parameter int CHANNELS = 8
) (
  input logic                clk,
  input logic                rst,
  input logic [CHANNELS-1:0] out_valid,
  input logic                frame_done,
  input logic                sel_err
);

  // At most one channel updates per cycle.
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid))
    else $error("seq_demux_chk: out_valid not one-hot");

  // A dropped word never updates a channel.
  a_drop: assert property (@(posedge clk) disable iff (rst) sel_err |-> (out_valid == {CHANNELS{1'b0}}))
    else $error("seq_demux_chk: sel_err with out_valid");

  // End of frame always coincides with the last channel's update.
  a_frame: assert property (@(posedge clk) disable iff (rst) frame_done |-> out_valid[CHANNELS-1])
    else $error("seq_demux_chk: frame_done without last channel update");

endmodule

// File: rtl/seq_demux.sv
// Sequential demultiplexer: routes each accepted input word into one of
// CHANNELS hold registers, either by explicit select or by an auto-advancing
// pointer. All outputs are registered; write latency is one cycle.
module seq_demux
  import seq_demux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      frame_done,
  output logic                      sel_err
);

  // Select values at or above this limit address no channel.
  localparam logic [SEL_W:0]   CH_LIMIT = CHANNELS[SEL_W:0];
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  // Registered state
  state_t              state_r;
  logic [SEL_W-1:0]    cur_ch_r;
  logic [CHANNELS-1:0] out_valid_r;
  logic                frame_done_r;
  logic                sel_err_r;

  // Combinational decode
  state_t              state_nxt_s;
  logic                auto_s;
  logic [SEL_W-1:0]    ptr_s;
  logic [SEL_W-1:0]    tgt_s;
  logic                sel_ok_s;
  logic                wr_s;
  logic                drop_s;
  logic                last_s;
  logic [SEL_W-1:0]    cur_ch_nxt_s;
  logic [CHANNELS-1:0] load_s;

  // Effective auto pointer: a fresh entry into auto mode always starts at
  // channel 0, so the word arriving with the mode change goes to channel 0.
  always_comb begin
    ptr_s = {SEL_W{1'b0}};
    case (state_r)
      ST_ADDR: ptr_s = {SEL_W{1'b0}};
      ST_AUTO: ptr_s = cur_ch_r;
      default: ptr_s = {SEL_W{1'b0}};
    endcase
  end

  // Decode target channel, write/drop strobes and the next pointer value.
  always_comb begin
    auto_s       = (mode == MODE_AUTO);
    state_nxt_s  = mode_to_state(mode);
    sel_ok_s     = ({1'b0, sel} < CH_LIMIT);
    tgt_s        = sel;
    wr_s         = 1'b0;
    drop_s       = 1'b0;
    cur_ch_nxt_s = cur_ch_r;

    if (auto_s) begin
      tgt_s  = ptr_s;
      wr_s   = in_valid;
      drop_s = 1'b0;
    end else begin
      tgt_s  = sel;
      wr_s   = in_valid && sel_ok_s;
      drop_s = in_valid && !sel_ok_s;
    end

    last_s = wr_s && auto_s && (ptr_s == LAST_CH);

    if (auto_s) begin
      if (in_valid) begin
        if (ptr_s == LAST_CH) begin
          cur_ch_nxt_s = {SEL_W{1'b0}};
        end else begin
          cur_ch_nxt_s = ptr_s + SEL_W'(1);
        end
      end else begin
        cur_ch_nxt_s = ptr_s;
      end
    end else begin
      cur_ch_nxt_s = cur_ch_r;
    end
  end

  // FSM state, auto pointer and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_ADDR;
      cur_ch_r     <= {SEL_W{1'b0}};
      out_valid_r  <= {CHANNELS{1'b0}};
      frame_done_r <= 1'b0;
      sel_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cur_ch_r     <= cur_ch_nxt_s;
      out_valid_r  <= load_s;
      frame_done_r <= last_s;
      sel_err_r    <= drop_s;
    end
  end

  // One hold register per channel, loaded when that channel is targeted.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign load_s[g] = wr_s && (tgt_s == SEL_W'(g));

    chan_hold_reg #(
      .WIDTH (WIDTH)
    ) u_hold (
      .clk  (clk),
      .rst  (rst),
      .load (load_s[g]),
      .d    (in_data),
      .q    (out_data[g*WIDTH +: WIDTH])
    );
  end

  assign out_valid  = out_valid_r;
  assign cur_ch     = cur_ch_r;
  assign frame_done = frame_done_r;
  assign sel_err    = sel_err_r;

  seq_demux_chk #(
    .CHANNELS (CHANNELS)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .out_valid  (out_valid_r),
    .frame_done (frame_done_r),
    .sel_err    (sel_err_r)
  );

endmodule

// File: tb/tb_seq_demux.sv
// Self-checking bench for seq_demux. Two instances (8 and 6 channels) share
// the same stimulus; a channel-array reference model predicts every output.
module tb_seq_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        mode = 1'b0;
  logic [2:0]  sel = 3'd0;

  logic [63:0] out_data8;
  logic [7:0]  out_valid8;
  logic [2:0]  cur_ch8;
  logic        frame_done8;
  logic        sel_err8;

  logic [47:0] out_data6;
  logic [5:0]  out_valid6;
  logic [2:0]  cur_ch6;
  logic        frame_done6;
  logic        sel_err6;

  int errors = 0;
  int checks = 0;
  int fd_seen8 = 0;

  // Reference model: per-DUT channel contents, auto pointer and pulses.
  int         nch [2] = '{8, 6};
  logic [7:0] m_hold [2][8];
  int         m_ptr [2];
  bit         m_auto [2];
  logic [7:0] m_ov [2];
  bit         m_fd [2];
  bit         m_se [2];

  seq_demux #(.WIDTH(8), .CHANNELS(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode), .sel(sel),
    .out_data(out_data8), .out_valid(out_valid8), .cur_ch(cur_ch8),
    .frame_done(frame_done8), .sel_err(sel_err8)
  );

  seq_demux #(.WIDTH(8), .CHANNELS(6)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode), .sel(sel),
    .out_data(out_data6), .out_valid(out_valid6), .cur_ch(cur_ch6),
    .frame_done(frame_done6), .sel_err(sel_err6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one edge of the demux rules to the model.
  function automatic void model_update(input bit v, input logic [7:0] d, input bit m,
                                       input int s, input bit r);
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 8'h00;
      m_fd[i] = 1'b0;
      m_se[i] = 1'b0;
      if (r) begin
        for (int k = 0; k < 8; k++) m_hold[i][k] = 8'h00;
        m_ptr[i]  = 0;
        m_auto[i] = 1'b0;
      end else if (m) begin
        if (!m_auto[i]) m_ptr[i] = 0;
        m_auto[i] = 1'b1;
        if (v) begin
          m_hold[i][m_ptr[i]] = d;
          m_ov[i] = 8'(1 << m_ptr[i]);
          if (m_ptr[i] == nch[i] - 1) begin
            m_fd[i]  = 1'b1;
            m_ptr[i] = 0;
          end else begin
            m_ptr[i] = m_ptr[i] + 1;
          end
        end
      end else begin
        m_auto[i] = 1'b0;
        if (v) begin
          if (s < nch[i]) begin
            m_hold[i][s] = d;
            m_ov[i] = 8'(1 << s);
          end else begin
            m_se[i] = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic logic [63:0] model_data(input int i);
    logic [63:0] e = 64'h0;
    for (int k = 0; k < nch[i]; k++) e[k*8 +: 8] = m_hold[i][k];
    return e;
  endfunction

  task automatic check_all();
    chk("d8_data",  out_data8,             model_data(0));
    chk("d8_valid", {56'h0, out_valid8},   {56'h0, m_ov[0]});
    chk("d8_cur",   {61'h0, cur_ch8},      64'(m_ptr[0]));
    chk("d8_fd",    {63'h0, frame_done8},  {63'h0, m_fd[0]});
    chk("d8_err",   {63'h0, sel_err8},     {63'h0, m_se[0]});
    chk("d6_data",  {16'h0, out_data6},    model_data(1));
    chk("d6_valid", {58'h0, out_valid6},   {56'h0, m_ov[1]});
    chk("d6_cur",   {61'h0, cur_ch6},      64'(m_ptr[1]));
    chk("d6_fd",    {63'h0, frame_done6},  {63'h0, m_fd[1]});
    chk("d6_err",   {63'h0, sel_err6},     {63'h0, m_se[1]});
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit m, input logic [2:0] s, input bit r);
    in_valid = v;
    in_data  = d;
    mode     = m;
    sel      = s;
    rst      = r;
    @(posedge clk);
    model_update(v, d, m, int'(s), r);
    #1;
    check_all();
    if (frame_done8 === 1'b1) fd_seen8++;
  endtask

  initial begin
    bit cur_mode;

    // Reset
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    chk("reset_data8", out_data8, 64'h0);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // Addressed sweep of 8'h55 over every select value
    for (int k = 0; k < 8; k++) step(1'b1, 8'h55, 1'b0, 3'(k), 1'b0);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    chk("addr_all55", out_data8, 64'h5555555555555555);

    // Auto frame 8'h10..8'h17
    fd_seen8 = 0;
    for (int k = 0; k < 8; k++) step(1'b1, 8'h10 + 8'(k), 1'b1, 3'd0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
    chk("auto_frame", out_data8, 64'h1716151413121110);
    chk("auto_fd_once", 64'(fd_seen8), 64'd1);
    chk("auto_wrap", {61'h0, cur_ch8}, 64'd0);

    // Invalid select on the 6-channel instance
    step(1'b1, 8'hAA, 1'b0, 3'd7, 1'b0);
    chk("sel7_err6", {63'h0, sel_err6}, 64'd1);
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

    // Mode switch: three auto words, one addressed, back to auto
    for (int k = 0; k < 3; k++) step(1'b1, 8'hE0 + 8'(k), 1'b1, 3'd0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 3'd5, 1'b0);
    step(1'b1, 8'h99, 1'b1, 3'd0, 1'b0);
    chk("switch_ch5", {56'h0, out_data8[47:40]}, 64'h3C);
    chk("switch_ch0", {56'h0, out_data8[7:0]}, 64'h99);

    // Mid-frame reset with a word present
    for (int k = 0; k < 4; k++) step(1'b1, 8'h40 + 8'(k), 1'b1, 3'd0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 3'd0, 1'b1);
    chk("rst_data8", out_data8, 64'h0);
    step(1'b1, 8'h77, 1'b1, 3'd0, 1'b0);
    chk("rst_next_ch0", out_data8, 64'h77);

    // Gaps in auto mode
    for (int k = 0; k < 10; k++) step(1'(k % 2 == 0), 8'hC0 + 8'(k), 1'b1, 3'd0, 1'b0);

    // Randomized traffic
    cur_mode = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), cur_mode, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
